// File: rtl/roi_stream_extractor.sv
// Crops a square window out of a raster pixel stream, optionally decimates it 2:1,
// and hands the result downstream through a show-ahead FIFO on a valid/ready stream.
module roi_stream_extractor #(
  parameter int unsigned IMG_WIDTH   = 64,
  parameter int unsigned IMG_HEIGHT  = 64,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   roi_load,
  input  logic [7:0]             roi_x,
  input  logic [7:0]             roi_y,
  input  logic [7:0]             roi_size,
  input  logic                   decim,
  input  logic                   frame_start,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  output logic [PIXEL_WIDTH-1:0] roi_pixel,
  output logic                   roi_valid,
  input  logic                   roi_ready,
  output logic                   roi_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   roi_err
);

  localparam int unsigned CW   = $clog2(IMG_WIDTH);
  localparam int unsigned RW   = $clog2(IMG_HEIGHT);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned GW   = 9;
  localparam int unsigned OW   = 2 * GW;
  localparam logic [GW-1:0] IMG_W9 = GW'(IMG_WIDTH);
  localparam logic [GW-1:0] IMG_H9 = GW'(IMG_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STREAM, S_DRAIN} state_e;

  state_e state_q, state_d;

  logic [GW-1:0]   x_lo_q, x_hi_q, y_lo_q, y_hi_q;
  logic            decim_q;
  logic [OW-1:0]   n_out_q, out_cnt_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            overflow_q, done_q, err_q;
  logic            done_d, err_d;
  logic [PIXEL_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Geometry check and clipping, evaluated on the roi_load cycle
  logic [GW-1:0] x9_c, y9_c, size9_c, avail_w_c, avail_h_c, eff_w_c, eff_h_c;
  logic [GW-1:0] cols_c, rows_c;
  logic          geom_bad_c, load_ok_c;

  always_comb begin
    x9_c       = {1'b0, roi_x};
    y9_c       = {1'b0, roi_y};
    size9_c    = {1'b0, roi_size};
    avail_w_c  = IMG_W9 - x9_c;
    avail_h_c  = IMG_H9 - y9_c;
    eff_w_c    = (size9_c < avail_w_c) ? size9_c : avail_w_c;
    eff_h_c    = (size9_c < avail_h_c) ? size9_c : avail_h_c;
    cols_c     = decim ? ((eff_w_c + GW'(1)) >> 1) : eff_w_c;
    rows_c     = decim ? ((eff_h_c + GW'(1)) >> 1) : eff_h_c;
    geom_bad_c = (roi_size == 8'd0) || (x9_c >= IMG_W9) || (y9_c >= IMG_H9);
    load_ok_c  = roi_load && (state_q == S_IDLE) && !geom_bad_c;
  end

  // Raster position, window membership and FIFO handshakes
  logic          pix_fire_c, frame_end_c, in_win_c, phase_ok_c;
  logic          empty_c, full_c, pop_c, push_c, drop_c;
  logic [GW-1:0] col9_c, row9_c;

  always_comb begin
    col9_c      = GW'(col_q);
    row9_c      = GW'(row_q);
    pix_fire_c  = pixel_valid && (state_q == S_STREAM);
    frame_end_c = pix_fire_c && (col_q == CW'(IMG_WIDTH - 1)) && (row_q == RW'(IMG_HEIGHT - 1));
    phase_ok_c  = !decim_q || (((col_q[0] ^ x_lo_q[0]) == 1'b0) && ((row_q[0] ^ y_lo_q[0]) == 1'b0));
    in_win_c    = (col9_c >= x_lo_q) && (col9_c < x_hi_q) &&
                  (row9_c >= y_lo_q) && (row9_c < y_hi_q) && phase_ok_c;
    empty_c     = (count_q == '0);
    full_c      = (count_q == CNTW'(FIFO_DEPTH));
    pop_c       = !empty_c && roi_ready;
    push_c      = pix_fire_c && in_win_c && (!full_c || pop_c);
    drop_c      = pix_fire_c && in_win_c && full_c && !pop_c;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load_ok_c)   state_d = S_ARMED;
      S_ARMED:  if (frame_start) state_d = S_STREAM;
      S_STREAM: if (frame_end_c) state_d = S_DRAIN;
      S_DRAIN:  if (empty_c)     state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done_d    = (state_q == S_DRAIN) && empty_c;
    err_d     = roi_load && (state_q == S_IDLE) && geom_bad_c;
    roi_valid = !empty_c;
    roi_pixel = empty_c ? '0 : mem_q[rd_ptr_q];
    roi_last  = !empty_c && (out_cnt_q == (n_out_q - OW'(1)));
  end

  assign done     = done_q;
  assign roi_err  = err_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_lo_q     <= '0;
      x_hi_q     <= '0;
      y_lo_q     <= '0;
      y_hi_q     <= '0;
      decim_q    <= 1'b0;
      n_out_q    <= '0;
      out_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (load_ok_c) begin
        x_lo_q     <= x9_c;
        x_hi_q     <= x9_c + eff_w_c;
        y_lo_q     <= y9_c;
        y_hi_q     <= y9_c + eff_h_c;
        decim_q    <= decim;
        n_out_q    <= OW'(cols_c) * OW'(rows_c);
        out_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else if (pop_c) begin
        out_cnt_q <= out_cnt_q + OW'(1);
      end
      if (drop_c) overflow_q <= 1'b1;
      // Raster counters restart on frame_start; that cycle's pixel is not counted
      if ((state_q == S_ARMED) && frame_start) begin
        col_q <= '0;
        row_q <= '0;
      end else if (pix_fire_c) begin
        if (col_q == CW'(IMG_WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage needs no reset; roi_pixel is masked while empty
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= pixel_in;
  end

endmodule

// File: tb/tb_roi_stream_extractor.sv
// Randomized bench for roi_stream_extractor with a queue-based reference model
// and directed end-of-frame checks on known pixel values.
module tb_roi_stream_extractor;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int FD = 16;

  logic       clk = 1'b0;
  logic       rst, roi_load, decim, frame_start, pixel_valid, roi_ready;
  logic [7:0] roi_x, roi_y, roi_size, pixel_in;
  logic [7:0] roi_pixel;
  logic       roi_valid, roi_last, busy, done, overflow, roi_err;

  always #5 clk = ~clk;

  roi_stream_extractor #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(8), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .roi_load(roi_load), .roi_x(roi_x), .roi_y(roi_y),
    .roi_size(roi_size), .decim(decim), .frame_start(frame_start),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .roi_pixel(roi_pixel),
    .roi_valid(roi_valid), .roi_ready(roi_ready), .roi_last(roi_last),
    .busy(busy), .done(done), .overflow(overflow), .roi_err(roi_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef enum int {M_IDLE, M_ARMED, M_STREAM, M_DRAIN} mphase_e;
  mphase_e    ph;
  logic [7:0] q[$];
  int         lx, ly, lw, lh, n_exp, out_cnt, col, row, win_cnt, salt;
  bit         ldec, m_ovf, m_done, m_err;
  int         gx, gy, gs;
  bit         gd;

  // Observations for directed end-of-frame checks
  logic [7:0] obs[$];
  int         last_idx, done_seen, err_seen, ovf_at;

  function automatic logic [7:0] pix_val(input int r, input int c);
    return 8'(((r * 64) + c) ^ salt);
  endfunction

  task automatic check_outputs();
    check("valid", 32'(roi_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("pixel", 32'(roi_pixel), 32'(q[0]));
      check("last", 32'(roi_last), 32'((out_cnt + 1) == n_exp));
    end
    check("busy", 32'(busy), 32'(ph != M_IDLE));
    check("done", 32'(done), 32'(m_done));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("roi_err", 32'(roi_err), 32'(m_err));
    if (done) done_seen++;
    if (roi_err) err_seen++;
    if (overflow && ovf_at < 0) ovf_at = win_cnt;
  endtask

  // One clock: check at negedge, drive, advance the model across the next posedge
  task automatic cycle(input bit r, input bit ld, input bit fs, input bit pv, input bit rdy);
    bit         pop, push, inw;
    int         ew, eh;
    logic [7:0] val;
    check_outputs();
    val = (ph == M_STREAM) ? pix_val(row, col) : 8'($urandom);
    rst = r; roi_load = ld; roi_x = 8'(gx); roi_y = 8'(gy); roi_size = 8'(gs); decim = gd;
    frame_start = fs; pixel_valid = pv; roi_ready = rdy; pixel_in = val;
    if (roi_valid && rdy && !r) begin
      obs.push_back(roi_pixel);
      if (roi_last) last_idx = obs.size();
    end
    m_done = 0;
    m_err  = 0;
    push   = 0;
    if (r) begin
      q.delete();
      ph    = M_IDLE;
      m_ovf = 0;
    end else begin
      pop = (q.size() > 0) && rdy;
      case (ph)
        M_IDLE: if (ld) begin
          if (gs == 0 || gx >= W || gy >= H) m_err = 1;
          else begin
            ew = (gs < W - gx) ? gs : W - gx;
            eh = (gs < H - gy) ? gs : H - gy;
            lx = gx; ly = gy; lw = ew; lh = eh; ldec = gd;
            n_exp = (gd ? (ew + 1) / 2 : ew) * (gd ? (eh + 1) / 2 : eh);
            out_cnt = 0; m_ovf = 0; ph = M_ARMED;
          end
        end
        M_ARMED: if (fs) begin ph = M_STREAM; col = 0; row = 0; end
        M_STREAM: if (pv) begin
          inw = col >= lx && col < lx + lw && row >= ly && row < ly + lh &&
                (!ldec || (((col - lx) % 2 == 0) && ((row - ly) % 2 == 0)));
          if (inw) begin
            win_cnt++;
            if (q.size() < FD || pop) push = 1;
            else m_ovf = 1;
          end
          if (col == W - 1 && row == H - 1) ph = M_DRAIN;
          if (col == W - 1) begin col = 0; row++; end
          else col++;
        end
        M_DRAIN: if (q.size() == 0) begin ph = M_IDLE; m_done = 1; end
        default: ph = M_IDLE;
      endcase
      if (pop) begin void'(q.pop_front()); out_cnt++; end
      if (push) q.push_back(val);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int x, input int y, input int s, input bit d,
                           input int rdy_pct, input int duty, input bit hold);
    int g;
    gx = x; gy = y; gs = s; gd = d;
    obs.delete(); last_idx = 0; done_seen = 0; err_seen = 0; ovf_at = -1; win_cnt = 0;
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 1, 1);
    g = 0;
    while (ph == M_STREAM && g < 30000) begin
      cycle(0, 0, 0, $urandom_range(0, 99) < duty, hold ? 1'b0 : ($urandom_range(0, 99) < rdy_pct));
      g++;
    end
    while (ph != M_IDLE && g < 31000) begin
      cycle(0, 0, 0, 0, $urandom_range(0, 99) < rdy_pct);
      g++;
    end
    if (g >= 31000) check("frame_timeout", 32'(g), 32'(0));
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; roi_load = 0; roi_x = 0; roi_y = 0; roi_size = 0; decim = 0;
    frame_start = 0; pixel_valid = 0; pixel_in = 0; roi_ready = 1;
    gx = 0; gy = 0; gs = 0; gd = 0; salt = 0;
    ph = M_IDLE; m_ovf = 0; m_done = 0; m_err = 0; out_cnt = 0; n_exp = 0;
    col = 0; row = 0; win_cnt = 0; ovf_at = -1;
    @(negedge clk);
    cycle(1, 0, 0, 0, 1);
    check("rst_pixel", 32'(roi_pixel), 32'(0));
    check("rst_last", 32'(roi_last), 32'(0));
    cycle(0, 0, 0, 0, 1);

    run_frame(10, 20, 24, 0, 100, 100, 0);
    check("a_count", 32'(obs.size()), 32'(576));
    check("a_first", 32'(obs[0]), 32'(8'h0A));
    check("a_lastpix", 32'(obs[575]), 32'(8'hE1));
    check("a_lastidx", 32'(last_idx), 32'(576));
    check("a_done", 32'(done_seen), 32'(1));
    check("a_ovf", 32'(overflow), 32'(0));

    run_frame(0, 0, 24, 1, 100, 100, 0);
    check("b_count", 32'(obs.size()), 32'(144));
    check("b_out2", 32'(obs[1]), 32'(8'h02));
    check("b_out13", 32'(obs[12]), 32'(8'h80));
    check("b_out144", 32'(obs[143]), 32'(8'h96));
    check("b_lastidx", 32'(last_idx), 32'(144));

    run_frame(50, 50, 24, 0, 100, 100, 0);
    check("c_count", 32'(obs.size()), 32'(196));
    check("c_lastpix", 32'(obs[195]), 32'(8'hFF));
    check("c_err", 32'(err_seen), 32'(0));

    run_frame(0, 0, 24, 0, 100, 100, 1);
    check("d_ovf_at", 32'(ovf_at), 32'(17));
    check("d_count", 32'(obs.size()), 32'(16));
    check("d_first", 32'(obs[0]), 32'(8'h00));
    check("d_lastpix", 32'(obs[15]), 32'(8'h0F));
    check("d_nolast", 32'(last_idx), 32'(0));
    check("d_done", 32'(done_seen), 32'(1));
    check("d_sticky", 32'(overflow), 32'(1));

    gx = 64; gy = 0; gs = 8; gd = 0; err_seen = 0;
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
    check("e_err", 32'(err_seen), 32'(1));
    check("e_busy", 32'(busy), 32'(0));

    gx = 0; gy = 0; gs = 64; gd = 0;
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    for (int i = 0; i < 1000; i++) cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 1);
    check("f_valid", 32'(roi_valid), 32'(0));
    check("f_busy", 32'(busy), 32'(0));
    check("f_pixel", 32'(roi_pixel), 32'(0));
    check("f_last", 32'(roi_last), 32'(0));
    cycle(0, 0, 0, 0, 1);
    run_frame(5, 7, 30, 1, 100, 100, 0);
    check("f_count", 32'(obs.size()), 32'(225));
    check("f_lastpix", 32'(obs[224]), 32'(8'hE1));
    check("f_done", 32'(done_seen), 32'(1));

    for (int k = 0; k < 4; k++) begin
      int rp;
      salt = int'($urandom_range(0, 255));
      rp = (k == 0) ? 100 : int'($urandom_range(60, 95));
      run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                int'($urandom_range(1, 80)), 1'($urandom_range(0, 1)),
                rp, int'($urandom_range(60, 100)), 0);
      check("r_done", 32'(done_seen), 32'(1));
      if (!m_ovf) begin
        check("r_count", 32'(obs.size()), 32'(n_exp));
        check("r_lastidx", 32'(last_idx), 32'(n_exp));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/roi_stream_extractor.md
# roi_stream_extractor

Synthesizable ROI extractor. It sits between the pixel source and the emotion-classifier interface, downstream of `face_detector`. Once detection has produced face coordinates, it accepts a window geometry and watches a raster pixel stream. It crops the square window, optionally decimates it 2:1, and delivers the result on a valid/ready stream through an internal FIFO. This replaces the fixed 24x24 software-side ROI hand-off with a parametrised hardware path.

## Interface
- IMG_WIDTH, 64, frame width in pixels
- IMG_HEIGHT, 64, frame height in pixels
- PIXEL_WIDTH, 8, bits per pixel
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2

- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- roi_load  in  1  one-cycle pulse that latches geometry
- roi_x  in  8  window left column
- roi_y  in  8  window top row
- roi_size  in  8  window side length in pixels
- decim  in  1  latched with roi_load; 0 = every pixel, 1 = keep even column and even row offsets only
- frame_start  in  1  pulse marking the next pixel_valid as pixel (0,0)
- pixel_in  in  PIXEL_WIDTH  raster pixel
- pixel_valid  in  1  pixel_in valid this cycle; no backpressure upstream
- roi_pixel  out  PIXEL_WIDTH  cropped pixel
- roi_valid  out  1  roi_pixel valid
- roi_ready  in  1  downstream accepts
- roi_last  out  1  qualifies the final ROI pixel
- busy  out  1  high in ARMED, STREAM and DRAIN
- done  out  1  one-cycle pulse at end of transfer
- overflow  out  1  sticky; an in-window pixel was dropped because the FIFO was full
- roi_err  out  1  one-cycle pulse; invalid geometry was rejected

## Operation
- States:
  - IDLE: roi_load with valid geometry -> ARMED; invalid geometry -> roi_err pulse, stay IDLE.
  - ARMED: frame_start -> STREAM.
  - STREAM: accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) -> DRAIN.
  - DRAIN: FIFO empty -> IDLE, with done pulsed on that transition.
- Invalid geometry: roi_size==0, or roi_x >= IMG_WIDTH, or roi_y >= IMG_HEIGHT.
- Clipping:
  - eff_w = min(roi_size, IMG_WIDTH-roi_x)
  - eff_h = min(roi_size, IMG_HEIGHT-roi_y)
  - Sums are computed 9 bits wide so they never wrap.
- Counters:
  - col and row, each clog2 wide, advance only on pixel_valid in STREAM.
  - col wraps at IMG_WIDTH-1, then row increments.
- In-window test: roi_x <= col < roi_x+eff_w and roi_y <= row < roi_y+eff_h. When decim=1, additionally (col-roi_x)[0]==0 and (row-roi_y)[0]==0.
- Push: an in-window pixel is written to the FIFO. If the FIFO is full, the pixel is dropped and overflow is set. The input stream is never stalled.
- Output count N = ceil(eff_w/(1+decim)) * ceil(eff_h/(1+decim)).
- roi_last is asserted with the Nth output, counted by an out-counter; it does not depend on the FIFO.
- Ignored inputs:
  - roi_load outside IDLE.
  - frame_start outside ARMED.
  - pixel_valid outside STREAM, including the frame_start cycle itself.
- overflow clears only on rst or on the next accepted roi_load.

## Timing
- Reset values: roi_valid=0, roi_last=0, busy=0, done=0, overflow=0, roi_err=0, roi_pixel=0, FIFO empty, state IDLE.
- rst mid-operation: everything returns to the reset state in the cycle after the rst edge. FIFO contents are discarded.
- Push latency: an in-window pixel accepted at edge k gives roi_valid=1 after edge k (FIFO show-ahead), provided the FIFO was empty.
- Handshake:
  - Transfer on roi_valid && roi_ready at posedge.
  - roi_pixel and roi_last are held stable while roi_valid && !roi_ready.
- Simultaneous push and pop on a full FIFO: the push is accepted and overflow is not set. Occupancy is unchanged.
- busy asserts the cycle after roi_load is accepted and deasserts in the same cycle done pulses.
- roi_err asserts the cycle after the rejected roi_load.
- Full throughput: one pixel per cycle in and out when roi_ready is held high.

## Test plan
Default parameters; pixel value = (row*64+col) & 0xFF; roi_ready=1 unless stated.
- ROI (10,20,24), decim=0: 576 outputs. First output 0x0A, last output 0xE1 with roi_last high. done pulses once and overflow stays 0.
- ROI (0,0,24), decim=1: 144 outputs. Output 2 = 0x02, output 13 = 0x80, output 144 = 0x96 with roi_last.
- ROI (50,50,24), clipped to 14x14: 196 outputs, last = 0xFF. No roi_err.
- ROI (0,0,24) with roi_ready=0 until end of frame: overflow sets on the 17th in-window pixel. Raising roi_ready then yields exactly 16 pixels, 0x00..0x0F, then done. roi_last does not appear.
- roi_x=64: roi_err pulses for one cycle, busy stays 0, and a subsequent frame_start is ignored.
- rst asserted after 1000 streamed pixels: all outputs return to reset values next cycle. A fresh roi_load plus frame_start then completes normally.
